// File: rtl/pc_sequencer.sv
// pc_sequencer
// Controls the core's program counter. It holds the PC in reset until
// start, issues branch commands from decoded instructions and ALU flags,
// inserts a one-cycle squash bubble after each taken branch, and freezes
// the PC on memory stalls, halt instructions and stall timeouts.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-low
//   start        level; IDLE -> RUN, and DONE/ERROR -> IDLE
//   instr_valid  decoder presents an instruction this cycle
//   is_branch    decoded instruction is a branch
//   is_halt      decoded instruction is halt
//   cond         00 always, 01 zero, 10 negative, 11 not-zero
//   br_offset    signed branch offset, forwarded unmodified
//   flag_zero    ALU zero flag
//   flag_neg     ALU negative flag
//   mem_stall    data memory busy; PC must not advance
//   pc_reset     program_counter reset (active-high)
//   pc_halt      program_counter hold
//   pc_branch    program_counter branch (PC += pc_offset)
//   pc_offset    branch offset, zero whenever pc_branch is low
//   done         halt instruction reached
//   stall_err    stall timeout occurred
//   taken_count  taken branches since leaving IDLE, saturating at 255
module pc_sequencer #(
  parameter int OFFSET_W = 8,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                instr_valid,
  input  logic                is_branch,
  input  logic                is_halt,
  input  logic [1:0]          cond,
  input  logic [OFFSET_W-1:0] br_offset,
  input  logic                flag_zero,
  input  logic                flag_neg,
  input  logic                mem_stall,
  output logic                pc_reset,
  output logic                pc_halt,
  output logic                pc_branch,
  output logic [OFFSET_W-1:0] pc_offset,
  output logic                done,
  output logic                stall_err,
  output logic [7:0]          taken_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    BUBBLE = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } state_t;

  // Counter value seen on the last tolerated stall cycle; one more stall
  // at this value makes TIMEOUT consecutive stalled cycles.
  localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [7:0] stall_cnt_reg, stall_cnt_next;
  logic [7:0] taken_cnt_reg, taken_cnt_next;
  logic       cond_true;
  logic       taken;

  always_comb begin
    cond_true = 1'b1;
    case (cond)
      2'b00:   cond_true = 1'b1;
      2'b01:   cond_true = flag_zero;
      2'b10:   cond_true = flag_neg;
      default: cond_true = ~flag_zero;
    endcase
  end

  assign taken       = instr_valid & is_branch & cond_true;
  assign taken_count = taken_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      stall_cnt_reg <= 8'd0;
      taken_cnt_reg <= 8'd0;
    end else begin
      state_reg     <= state_next;
      stall_cnt_reg <= stall_cnt_next;
      taken_cnt_reg <= taken_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    stall_cnt_next = stall_cnt_reg;
    taken_cnt_next = taken_cnt_reg;
    pc_reset       = 1'b0;
    pc_halt        = 1'b1;
    pc_branch      = 1'b0;
    pc_offset      = '0;
    done           = 1'b0;
    stall_err      = 1'b0;

    case (state_reg)
      IDLE: begin
        pc_reset       = 1'b1;
        stall_cnt_next = 8'd0;
        taken_cnt_next = 8'd0;
        if (start) begin
          state_next = RUN;
        end
      end

      RUN: begin
        // Priority: stall, then halt, then taken branch, then increment.
        if (mem_stall) begin
          stall_cnt_next = stall_cnt_reg + 8'd1;
          if (stall_cnt_reg == STALL_LAST) begin
            state_next = ERROR;
          end
        end else begin
          stall_cnt_next = 8'd0;
          if (instr_valid && is_halt) begin
            state_next = DONE;
          end else if (taken) begin
            pc_halt        = 1'b0;
            pc_branch      = 1'b1;
            pc_offset      = br_offset;
            taken_cnt_next = (taken_cnt_reg == 8'hFF) ? 8'hFF : taken_cnt_reg + 8'd1;
            state_next     = BUBBLE;
          end else begin
            pc_halt = 1'b0;
          end
        end
      end

      // The instruction fetched behind a taken branch is on the wrong
      // path: hold the PC for one cycle and ignore the decoder. Stalls
      // here are not counted toward the timeout.
      BUBBLE: begin
        state_next = RUN;
      end

      DONE: begin
        done = 1'b1;
        if (start) begin
          state_next     = IDLE;
          stall_cnt_next = 8'd0;
          taken_cnt_next = 8'd0;
        end
      end

      ERROR: begin
        stall_err = 1'b1;
        if (start) begin
          state_next     = IDLE;
          stall_cnt_next = 8'd0;
          taken_cnt_next = 8'd0;
        end
      end

      default: begin
        pc_reset   = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that sequences the 8-bit program_counter in the core: releases it from reset on start, commands branches from decoded instructions and condition flags, and freezes it on memory stalls, halt instructions and stall timeouts.
- Sits between the instruction decoder/flag register and program_counter's reset/halt/branch/offset inputs.
- Inserts a one-cycle squash bubble after every taken branch.

Parameters:
OFFSET_W, 8, width of branch offset (two's complement); matches program_counter offset width
TIMEOUT, 16, consecutive mem_stall cycles in RUN that trigger the ERROR state (range 2..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  one clock; reset is synchronous and active-low
start  input  1  level; launches execution from IDLE, returns DONE/ERROR to IDLE
instr_valid  input  1  decoder presents a valid instruction this cycle
is_branch  input  1  decoded instruction is a branch
is_halt  input  1  decoded instruction is halt
cond  input  2  branch condition: 00 always, 01 zero, 10 negative, 11 not-zero
br_offset  input  OFFSET_W  signed branch offset from decoder
flag_zero  input  1  ALU zero flag
flag_neg  input  1  ALU negative flag
mem_stall  input  1  data memory busy; PC must not advance
pc_reset  output  1  to program_counter reset (active-high)
pc_halt  output  1  to program_counter halt
pc_branch  output  1  to program_counter branch
pc_offset  output  OFFSET_W  to program_counter offset
done  output  1  program reached halt instruction
stall_err  output  1  stall timeout occurred
taken_count  output  8  number of taken branches since leaving IDLE, saturating

Behaviour:
- States: IDLE, RUN, BUBBLE, DONE, ERROR; state registered; pc_* outputs are combinational from state and inputs (Mealy in RUN only).
- Reset (reset==0 at rising edge): next state IDLE from any state, including mid-branch or mid-stall. stall_cnt=0, taken_count=0, done=0, stall_err=0.
- Output values after reset: pc_reset=1, pc_halt=1, pc_branch=0, pc_offset=0.
- IDLE: pc_reset=1, pc_halt=1, pc_branch=0, pc_offset=0. start=1 -> RUN.
- RUN: pc_reset=0. Per-cycle priority: mem_stall > is_halt > branch > increment.
  - mem_stall=1: pc_halt=1, pc_branch=0; stall_cnt+1. When stall_cnt reaches TIMEOUT-1 with mem_stall still 1 -> ERROR (TIMEOUT stalled cycles total). mem_stall=0 clears stall_cnt.
  - instr_valid & is_halt (no stall): pc_halt=1 -> DONE. If is_branch is also set, halt wins and no branch is issued.
  - taken = instr_valid & is_branch & cond_true, where cond_true = 1 (00), flag_zero (01), flag_neg (10), !flag_zero (11).
  - taken (no stall, no halt): pc_branch=1, pc_offset=br_offset, pc_halt=0; taken_count+1, saturating at 255 (no wrap) -> BUBBLE.
  - Not-taken branch or other instruction: pc_halt=0, pc_branch=0, pc_offset=0 (PC increments); stay in RUN.
  - instr_valid=0 and no stall: PC increments (fetch continues).
- BUBBLE: exactly one cycle.
  - pc_halt=1, pc_branch=0; decoder inputs ignored (squashes the wrong-path instruction).
  - Next state RUN, regardless of mem_stall; a stall seen in BUBBLE is not counted.
- DONE: done=1, pc_halt=1, pc_reset=0 (PC holds final address). start=1 -> IDLE.
- ERROR: stall_err=1, pc_halt=1, pc_reset=0. start=1 -> IDLE.
- Entering IDLE from DONE/ERROR clears done, stall_err, taken_count and stall_cnt in the same edge. A further start is required to run again, so start held high gives IDLE then RUN on consecutive cycles.
- pc_offset is 0 whenever pc_branch=0. Offset is passed unmodified; wrap-around of the PC is program_counter's responsibility.
- Negative offsets (e.g. 8'hF6 = -10) pass through as bit patterns.

Test Plan:
- Reset held low 2 cycles, then start=1 for 1 cycle with no instructions -> pc_reset=1 until the start edge; PC goes 0,1,2,3,4,5 over the next 5 cycles; taken_count=0.
- In RUN, branch cond=00, br_offset=20, at PC=5 -> pc_branch=1 and pc_offset=20 for one cycle; next cycle pc_halt=1 (BUBBLE); PC=25 then 26; taken_count=1.
- cond=01 with flag_zero=0, offset=-10 -> no branch, PC increments. Repeat with flag_zero=1 at PC=30 -> PC=20, taken_count=2.
- mem_stall=1 for 3 cycles at PC=8 -> PC holds 8, no ERROR. With TIMEOUT=16, mem_stall held 16 cycles -> stall_err=1 and pc_halt=1 from cycle 17; start -> IDLE with stall_err=0.
- is_halt and is_branch both set at PC=12 -> no pc_branch, DONE with done=1, PC stays 12, taken_count unchanged.
- reset driven low during BUBBLE -> next cycle IDLE, pc_reset=1, taken_count=0. With 256 taken branches, taken_count saturates at 255.
